// File: rtl/biu_traffic_master.sv
// biu_traffic_master: bus traffic generator for the BIU master request port.
//   MIRROR (i_mode=0): writes the debounced switch value, replicated across the
//                      data word, to BASE_ADDR whenever it settles to a new value.
//   SWEEP  (i_mode=1): on i_start, writes NUM_WORDS words of rep(sw)^k, reads
//                      them back, and counts mismatches in o_err_count.
//   A watchdog completes any transaction that waits TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_sw                            asynchronous switch inputs
//   i_mode, i_start                 mode select / sweep start (sampled in IDLE)
//   o_address, o_data_out, o_rnw    request fields, held through the request
//   o_en                            request strobe (request state and not busy)
//   i_data_in, i_data_valid, i_busy BIU response side
//   o_done                          one-cycle pulse at sweep end
//   o_err_count                     saturating mismatch + timeout count
//   o_timeout                       sticky watchdog flag
//   o_last_rdata                    most recent valid read data
module biu_traffic_master #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SW_WIDTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'hC000_0000,
  parameter int                    ADDR_STRIDE    = 4,
  parameter int                    NUM_WORDS      = 4,
  parameter int                    STABLE_CYCLES  = 3,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW_WIDTH-1:0]   i_sw,
  input  logic                  i_mode,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_rnw,
  output logic                  o_en,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_data_valid,
  input  logic                  i_busy,
  output logic                  o_done,
  output logic [15:0]           o_err_count,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-1:0] o_last_rdata
);

  localparam int K_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REP  = DATA_WIDTH / SW_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q, baseline_q, baseline_d, pat_q, pat_d;
  logic [SC_W-1:0]       stable_cnt_q, stable_cnt_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [K_W-1:0]        k_q, k_d;
  logic                  mode_q, mode_d;
  logic [15:0]           err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rnw_q, rnw_d, done_q;

  logic change_s, start_s, mirror_s, req_state_s, wait_state_s, accept_s;
  logic wr_cpl_s, rd_cpl_s, wd_exp_s, cpl_s, last_word_s, err_inc_s;

  // Word k of a sweep: replicated switch pattern with k folded into the low bits.
  function automatic logic [DATA_WIDTH-1:0] word_pattern(input logic [SW_WIDTH-1:0] sw,
                                                         input logic [K_W-1:0] k);
    return {REP{sw}} ^ DATA_WIDTH'(k);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [K_W-1:0] k);
    return BASE_ADDR + (ADDR_WIDTH'(k) * ADDR_WIDTH'(ADDR_STRIDE));
  endfunction

  assign req_state_s  = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign wait_state_s = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
  assign accept_s     = req_state_s && !i_busy;
  assign wr_cpl_s     = (state_q == S_WR_WAIT) && !i_busy;
  assign rd_cpl_s     = (state_q == S_RD_WAIT) && i_data_valid;
  // A genuine completion in the expiry cycle wins over the watchdog.
  assign wd_exp_s     = wait_state_s && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) && !(wr_cpl_s || rd_cpl_s);
  assign cpl_s        = wr_cpl_s || rd_cpl_s || wd_exp_s;
  assign last_word_s  = (k_q == K_W'(NUM_WORDS - 1));
  // stable_cnt_q == STABLE_CYCLES means the synced value has held that long.
  assign change_s     = (stable_cnt_q == SC_W'(STABLE_CYCLES)) && (sw_sync_q != baseline_q);
  assign start_s      = (state_q == S_IDLE) && i_mode && i_start;
  assign mirror_s     = (state_q == S_IDLE) && !i_mode && change_s;
  assign err_inc_s    = wd_exp_s || (rd_cpl_s && (i_data_in != data_q));

  // Switch synchroniser and stability counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q    <= SW_WIDTH'(0);
      sw_sync_q    <= SW_WIDTH'(0);
      stable_cnt_q <= SC_W'(0);
    end else begin
      sw_meta_q    <= i_sw;
      sw_sync_q    <= sw_meta_q;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  // Stability count: restarts when the synced value is about to change, saturates
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (sw_meta_q != sw_sync_q) begin
      stable_cnt_d = SC_W'(0);
    end else if (stable_cnt_q != SC_W'(STABLE_CYCLES)) begin
      stable_cnt_d = stable_cnt_q + SC_W'(1);
    end else begin
      stable_cnt_d = stable_cnt_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_s || mirror_s) state_d = S_WR_REQ; else state_d = S_IDLE;
      S_WR_REQ:  if (accept_s) state_d = S_WR_WAIT; else state_d = S_WR_REQ;
      S_WR_WAIT: begin
        if (!cpl_s)            state_d = S_WR_WAIT;
        else if (!mode_q)      state_d = S_IDLE;
        else if (last_word_s)  state_d = S_RD_REQ;
        else                   state_d = S_WR_REQ;
      end
      S_RD_REQ:  if (accept_s) state_d = S_RD_WAIT; else state_d = S_RD_REQ;
      S_RD_WAIT: begin
        if (!cpl_s)            state_d = S_RD_WAIT;
        else if (last_word_s)  state_d = S_DONE;
        else                   state_d = S_RD_REQ;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the request strobe is gated directly by i_busy
  always_comb begin
    o_en = 1'b0;
    if (req_state_s) begin
      o_en = !i_busy;
    end else begin
      o_en = 1'b0;
    end
  end

  // Datapath next values: word index, pattern, baseline, watchdog, status
  always_comb begin
    k_d        = k_q;
    pat_d      = pat_q;
    mode_d     = mode_q;
    baseline_d = baseline_q;
    rdata_d    = rdata_q;
    if (start_s) begin
      mode_d = 1'b1;
      pat_d  = sw_sync_q;
      k_d    = K_W'(0);
    end else if (mirror_s) begin
      mode_d = 1'b0;
      pat_d  = sw_sync_q;
      k_d    = K_W'(0);
    end else if ((state_q == S_WR_WAIT) && cpl_s) begin
      if (!mode_q)          baseline_d = pat_q;
      else if (last_word_s) k_d = K_W'(0);
      else                  k_d = k_q + K_W'(1);
    end else if ((state_q == S_RD_WAIT) && cpl_s) begin
      if (last_word_s) k_d = K_W'(0); else k_d = k_q + K_W'(1);
      if (rd_cpl_s) rdata_d = i_data_in; else rdata_d = rdata_q;
    end else begin
      k_d = k_q;
    end

    if (accept_s)          wdog_d = WD_W'(0);
    else if (wait_state_s) wdog_d = wdog_q + WD_W'(1);
    else                   wdog_d = wdog_q;

    if (start_s)                                err_d = 16'h0000;
    else if (err_inc_s && (err_q != 16'hFFFF))  err_d = err_q + 16'h0001;
    else                                        err_d = err_q;

    tmo_d  = tmo_q || wd_exp_s;
    addr_d = word_addr(k_d);
    data_d = word_pattern(pat_d, k_d);
    rnw_d  = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT);
  end

  // Datapath and BIU-facing output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= K_W'(0);
      pat_q      <= SW_WIDTH'(0);
      mode_q     <= 1'b0;
      baseline_q <= SW_WIDTH'(0);
      wdog_q     <= WD_W'(0);
      err_q      <= 16'h0000;
      tmo_q      <= 1'b0;
      rdata_q    <= DATA_WIDTH'(0);
      addr_q     <= BASE_ADDR;
      data_q     <= DATA_WIDTH'(0);
      rnw_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      k_q        <= k_d;
      pat_q      <= pat_d;
      mode_q     <= mode_d;
      baseline_q <= baseline_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rnw_q      <= rnw_d;
      done_q     <= (state_d == S_DONE);
    end
  end

  assign o_address    = addr_q;
  assign o_data_out   = data_q;
  assign o_rnw        = rnw_q;
  assign o_done       = done_q;
  assign o_err_count  = err_q;
  assign o_timeout    = tmo_q;
  assign o_last_rdata = rdata_q;

endmodule

// File: tb/tb_biu_traffic_master.sv
module tb_biu_traffic_master;
  localparam logic [31:0] BASE = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_sw;
  logic        i_mode, i_start;
  logic [31:0] o_address, o_data_out, i_data_in, o_last_rdata;
  logic        o_rnw, o_en, i_data_valid, i_busy, o_done, o_timeout;
  logic [15:0] o_err_count;

  biu_traffic_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_sw(i_sw), .i_mode(i_mode), .i_start(i_start),
    .o_address(o_address), .o_data_out(o_data_out), .o_rnw(o_rnw), .o_en(o_en),
    .i_data_in(i_data_in), .i_data_valid(i_data_valid), .i_busy(i_busy),
    .o_done(o_done), .o_err_count(o_err_count), .o_timeout(o_timeout),
    .o_last_rdata(o_last_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic rnw; } acc_t;
  typedef struct { logic [15:0] sw; int busy_cyc; logic [31:0] exp_data; } mir_vec_t;
  typedef struct {
    logic [15:0] sw; int corrupt; int drop;
    logic [15:0] exp_err; logic [31:0] exp_last; logic exp_tmo;
  } swp_vec_t;

  acc_t        log_q[$];
  logic [31:0] mem [0:255];
  logic        busy_force = 1'b0;
  int          corrupt_idx = -1;
  int          drop_idx = -1;
  bit          rd_pending = 1'b0;
  int          rd_idx = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en"}, {31'd0, o_en}, 32'd0);
    chk({tag, "_rnw"}, {31'd0, o_rnw}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
    chk({tag, "_err"}, {16'd0, o_err_count}, 32'd0);
    chk({tag, "_last_rdata"}, o_last_rdata, 32'd0);
    chk({tag, "_address"}, o_address, BASE);
    chk({tag, "_data_out"}, o_data_out, 32'd0);
  endtask

  // Slave model: drives responses on the falling edge, then logs any request
  // that will be accepted at the next rising edge.
  always @(negedge clk) begin
    int idx;
    i_data_valid = 1'b0;
    if (rst) begin
      rd_pending = 1'b0;
    end else if (rd_pending) begin
      rd_pending = 1'b0;
      if (rd_idx != drop_idx) begin
        i_data_valid = 1'b1;
        i_data_in = mem[rd_idx] ^ ((rd_idx == corrupt_idx) ? 32'h1 : 32'h0);
      end
    end
    i_busy = busy_force;
    #1;
    if (o_en) begin
      log_q.push_back('{o_address, o_data_out, o_rnw});
      idx = int'((o_address - BASE) >> 2) & 255;
      if (o_rnw) begin
        rd_pending = 1'b1;
        rd_idx = idx;
      end else begin
        mem[idx] = o_data_out;
      end
    end
  end

  initial begin
    mir_vec_t mv [4];
    swp_vec_t sv [5];
    acc_t a;
    int lat, n, sz, k;
    bit done_seen;
    logic [31:0] exp_w;

    mv[0] = '{16'hA5A5, 0,  32'hA5A5A5A5};
    mv[1] = '{16'h1234, 16, 32'h12341234};
    mv[2] = '{16'hFFFF, 0,  32'hFFFFFFFF};
    mv[3] = '{16'h0000, 0,  32'h00000000};
    sv[0] = '{16'h1234, -1, -1, 16'd0, 32'h12341237, 1'b0};
    sv[1] = '{16'h1234,  2, -1, 16'd1, 32'h12341237, 1'b0};
    sv[2] = '{16'hABCD,  3, -1, 16'd1, 32'hABCDABCF, 1'b0};
    sv[3] = '{16'h0000, -1, -1, 16'd0, 32'h00000003, 1'b0};
    sv[4] = '{16'h1234, -1,  1, 16'd1, 32'h12341237, 1'b1};

    i_data_in = 32'd0;
    i_data_valid = 1'b0;
    i_busy = 1'b0;
    rst = 1'b1; i_sw = 16'h0000; i_mode = 1'b0; i_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset("reset");

    // Glitch shorter than the stability window must not produce a write.
    log_q.delete();
    i_sw = 16'h0001;
    tick(); tick();
    i_sw = 16'h0000;
    repeat (20) tick();
    chk("glitch_no_req", log_q.size(), 32'd0);

    // MIRROR vectors
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      if (mv[i].busy_cyc > 0) begin
        busy_force = 1'b1;
        tick();
      end
      i_sw = mv[i].sw;
      if (mv[i].busy_cyc == 0) begin
        lat = 0;
        n = 0;
        while (n < 40 && lat == 0) begin
          n++;
          tick();
          if (o_en) lat = n;
        end
        chk("mirror_latency", lat, 32'd6);
      end else begin
        repeat (mv[i].busy_cyc) tick();
        chk("busy_no_req", log_q.size(), 32'd0);
        chk("busy_en_low", {31'd0, o_en}, 32'd0);
        chk("busy_addr_held", o_address, BASE);
        chk("busy_data_held", o_data_out, mv[i].exp_data);
        busy_force = 1'b0;
        @(negedge clk);
        #2;
        chk("busy_drop_en", {31'd0, o_en}, 32'd1);
      end
      repeat (15) tick();
      chk("mirror_count", log_q.size(), 32'd1);
      if (log_q.size() > 0) begin
        a = log_q.pop_front();
        chk("mirror_addr", a.addr, BASE);
        chk("mirror_data", a.data, mv[i].exp_data);
        chk("mirror_rnw", {31'd0, a.rnw}, 32'd0);
      end
    end

    // SWEEP vectors
    i_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_sw = sv[i].sw;
      corrupt_idx = sv[i].corrupt;
      drop_idx = sv[i].drop;
      repeat (6) tick();
      log_q.delete();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      done_seen = 1'b0;
      n = 0;
      while (n < 400 && !done_seen) begin
        n++;
        tick();
        if (o_done) done_seen = 1'b1;
      end
      chk("sweep_done", {31'd0, done_seen}, 32'd1);
      chk("sweep_err", {16'd0, o_err_count}, {16'd0, sv[i].exp_err});
      chk("sweep_last_rdata", o_last_rdata, sv[i].exp_last);
      chk("sweep_timeout", {31'd0, o_timeout}, {31'd0, sv[i].exp_tmo});
      tick();
      chk("done_one_cycle", {31'd0, o_done}, 32'd0);
      chk("sweep_len", log_q.size(), 32'd8);
      for (int j = 0; j < 8; j++) begin
        if (log_q.size() > 0) begin
          a = log_q.pop_front();
          k = j % 4;
          chk("sweep_addr", a.addr, BASE + 32'(4 * k));
          chk("sweep_rnw", {31'd0, a.rnw}, (j >= 4) ? 32'd1 : 32'd0);
          if (j < 4) begin
            exp_w = {sv[i].sw, sv[i].sw} ^ 32'(k);
            chk("sweep_wdata", a.data, exp_w);
          end
        end
      end
    end

    // Timeout stays sticky across a new sweep; reset mid-sweep clears all.
    drop_idx = -1;
    corrupt_idx = -1;
    i_sw = 16'h5A5A;
    repeat (6) tick();
    log_q.delete();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (n < 100 && log_q.size() < 3) begin
      n++;
      tick();
    end
    chk("midsweep_progress", (log_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    chk("timeout_sticky", {31'd0, o_timeout}, 32'd1);
    chk("err_cleared_on_start", {16'd0, o_err_count}, 32'd0);
    rst = 1'b1;
    tick();
    check_reset("midsweep_reset");
    tick();
    rst = 1'b0;
    sz = log_q.size();
    repeat (12) tick();
    chk("no_req_after_reset", log_q.size(), sz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_traffic_master.md
Name: biu_traffic_master

Overview:
- Parametrised bus traffic generator driving the BIU master request interface.
- Mode 0 (MIRROR): writes debounced switch values to one slave word whenever they change.
- Mode 1 (SWEEP): on command, writes a pattern across NUM_WORDS consecutive slave words, reads them back, compares, and reports mismatches.
- Sits between board switches and biu_master in bring-up tops; includes a response watchdog so a dead slave cannot hang it.

Parameters:
ADDR_WIDTH, 32, BIU address width
DATA_WIDTH, 32, BIU data width; must be an integer multiple of SW_WIDTH
SW_WIDTH, 16, switch input width
BASE_ADDR, 32'hC0000000, address of word 0
ADDR_STRIDE, 4, byte increment between words
NUM_WORDS, 4, sweep length (1..256)
STABLE_CYCLES, 3, cycles synced switches must hold before counting as a change (>=1)
TIMEOUT_CYCLES, 1024, max wait cycles for a transaction to complete

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
i_sw  in  SW_WIDTH  asynchronous switch inputs
i_mode  in  1  0=MIRROR, 1=SWEEP; sampled only in IDLE
i_start  in  1  sweep start pulse; sampled only in IDLE with i_mode=1
o_address  out  ADDR_WIDTH  BIU request address
o_data_out  out  DATA_WIDTH  BIU write data
o_rnw  out  1  1=read, 0=write
o_en  out  1  BIU request strobe
i_data_in  in  DATA_WIDTH  BIU read data
i_data_valid  in  1  read data valid pulse
i_busy  in  1  BIU busy
o_done  out  1  one-cycle pulse at sweep end
o_err_count  out  16  sweep mismatches plus timeouts; saturating
o_timeout  out  1  sticky; set on any watchdog expiry
o_last_rdata  out  DATA_WIDTH  most recent read data

Behaviour:
- Switch sync: 2-flop synchroniser on i_sw, reset to 0.
- Stability counter: counts consecutive cycles with unchanged synced value.
- Change event: synced value has been stable for STABLE_CYCLES and differs from the last-written baseline.
- Baseline resets to 0, so nonzero switches at reset produce one write.
- Replication: rep(x) = x concatenated DATA_WIDTH/SW_WIDTH times.
- Sweep word k:
  - address = BASE_ADDR + k*ADDR_STRIDE
  - data = rep(synced sw captured at start) XOR k, with k zero-extended
- Request handshake:
  - o_en = req_state & ~i_busy (combinational gate).
  - A request is accepted in the cycle where o_en=1.
  - o_address, o_data_out and o_rnw are stable throughout req_state.
- Completion:
  - Write: first cycle after acceptance with i_busy=0.
  - Read: i_data_valid=1. On that cycle, capture i_data_in into o_last_rdata.
- Watchdog:
  - Counter cleared on acceptance, runs during WR_WAIT/RD_WAIT.
  - When it reaches TIMEOUT_CYCLES: treat the transaction as complete, set o_timeout, increment o_err_count.
  - A timed-out read performs no compare and does not update o_last_rdata.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
  - IDLE: if i_mode=1 and i_start:
    - clear o_err_count, capture switch pattern, k=0 -> WR_REQ.
    - o_timeout is NOT cleared here; only rst clears it.
  - IDLE: else if i_mode=0 and change event: k=0, data=rep(synced sw) -> WR_REQ. i_start takes priority when both are true in mode 1.
  - WR_REQ -> WR_WAIT on acceptance.
  - WR_WAIT on completion:
    - MIRROR: baseline <= written value -> IDLE.
    - SWEEP: k<NUM_WORDS-1 -> k+1, WR_REQ; else k=0 -> RD_REQ.
  - RD_REQ -> RD_WAIT on acceptance.
  - RD_WAIT on completion:
    - Compare against the expected pattern for k; on mismatch increment o_err_count (saturate at 16'hFFFF).
    - Then k+1 -> RD_REQ, or -> DONE after word NUM_WORDS-1.
  - DONE: o_done=1 for exactly one cycle -> IDLE.
- Events ignored outside IDLE:
  - Switch changes during a sweep do not modify the baseline; a pending difference is written in MIRROR after return to IDLE.
  - i_start and i_mode changes are ignored outside IDLE.
- i_data_valid outside RD_WAIT is ignored.
- Reset values:
  - o_en=0, o_rnw=0, o_done=0, o_timeout=0, o_err_count=0, o_last_rdata=0.
  - o_address=BASE_ADDR, o_data_out=0, state IDLE.
- Reset mid-transaction: o_en is low in the cycle after rst is sampled; no further requests are issued.
- Latency: a switch change reaches o_en after 2 sync cycles + STABLE_CYCLES + 1 cycle, when i_busy=0.

Test Plan:
- Reset, MIRROR, i_sw 16'h0000 -> 16'hA5A5, i_busy=0:
  - exactly one o_en pulse, address 32'hC0000000, data 32'hA5A5A5A5, o_rnw=0.
  - No further request while i_sw is held.
- MIRROR glitch: i_sw toggles 16'h0001 for 2 cycles then back to 0 (STABLE_CYCLES=3) -> no o_en.
- MIRROR with i_busy held high 10 cycles after a change:
  - o_en stays low and address/data are held.
  - o_en pulses in the first cycle i_busy drops.
- SWEEP, i_sw=16'h1234, responsive slave model returning written data:
  - writes to C0000000/4/8/C with data 12341234, 12341235, 12341236, 12341237.
  - then 4 reads of the same addresses, o_done pulse, o_err_count=0.
- SWEEP with the slave model corrupting word 2 read (bit 0 flipped) -> o_err_count=1, o_last_rdata=word 3 data.
- SWEEP with i_data_valid never asserted on word 1, TIMEOUT_CYCLES=16:
  - o_timeout set, o_err_count=1 after word 1, sweep continues, o_done asserted.
  - Then assert rst mid-sweep -> o_en=0 next cycle and all outputs at reset values.
